seq_approx_divider: RTL
=======================

Name: seq_approx_divider

Overview:
- Iterative (one quotient bit per cycle) restoring divider; parametrised successor of the combinational triangular array dividers.
- Configurable count of least-significant subtractor bit positions uses the approximate cell; approximation can be switched on or off per operation.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides.
- Used for area/error exploration of approximate dividers in clocked datapaths.

Parameters:
- DW, 8, divisor width and remainder width.
- QW, 8, quotient width; the dividend width is NW = QW+DW.
- APPROX_LSB, 2, number of low bit positions (0..DW) of each trial subtraction that use the approximate cell when approximation is enabled.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  the block accepts operands.
- n  in  QW+DW  dividend.
- d  in  DW  divisor.
- approx_en  in  1  sampled with operands; 1 = approximate cells active.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- q  out  QW  quotient.
- r  out  DW  remainder.
- div_zero  out  1  d was 0.
- ovf  out  1  n[NW-1:QW] >= d, so the quotient is truncated.

Behaviour:
- States: IDLE, RUN, DONE. Reset puts the block in IDLE.
- Reset values: in_ready=1, out_valid=0, q=0, r=0, div_zero=0, ovf=0, step counter=0.
- IDLE:
  - in_ready=1.
  - When in_valid=1, latch d and approx_en, set R=n[NW-1:QW], and latch the low dividend bits.
  - Compute ovf = (n[NW-1:QW] >= d) and div_zero = (d==0), both with exact arithmetic. Then go to RUN with i=QW-1.
- RUN (in_ready=0), one step per cycle:
  - T = {R, n[i]} (DW+1 bits).
  - Compute {borrow, diff} = T[DW-1:0] - d with a bitwise ripple borrow chain.
  - q[i] = T[DW] | ~borrow.
  - R = q[i] ? diff : T[DW-1:0].
  - After step i=0, go to DONE.
- Approximate cell, used at bit positions < APPROX_LSB when approx_en=1:
  - bout = ~x & y, ignoring the borrow-in.
  - diff = x.
  - The incoming borrow to that bit position is discarded.
  - Exact cell: diff = x^y^bin; bout = (~x&y) | (~(x^y)&bin).
- Latency: operands accepted at cycle 0 produce out_valid=1 at cycle QW+1.
- DONE:
  - out_valid=1; q, r (=R), div_zero and ovf stay stable until out_ready=1.
  - When out_ready=1, go to IDLE; out_valid clears on the next edge.
  - No new operand is accepted in the same cycle (throughput is one result per QW+2 cycles).
- Divide by zero:
  - This case is not special-cased in the datapath; it falls out of the algorithm.
  - Every q bit is 1, so q = all ones.
  - The same holds in approximate mode, because bout=0 at every bit when d=0.
  - r = n[DW-1:0] in exact mode.
  - div_zero=1.
- The outputs q, r, div_zero and ovf hold their last values in IDLE.
- If rst asserts mid-RUN or in DONE, the operation is dropped and all outputs return to their reset values.
- in_valid is ignored while the block is not in IDLE; the producer must hold the operands only until the handshake completes.
- APPROX_LSB=0 gives an exact divider regardless of approx_en.
- APPROX_LSB=DW makes every bit position approximate.

Optional Feature:
- Macro: SEQ_APPROX_DIVIDER_STATS_EN.
- When defined:
  - Extra output port err_cnt (16 bits, reset 0).
  - err_cnt increments by 1, saturating at 16'hFFFF, on each completed output handshake where approx_en was 1 and the approximate q differs from the exact quotient.
  - To support this, a shadow exact datapath runs in parallel during RUN.
- When undefined: no port, no shadow datapath; behaviour is otherwise identical.

Test Plan:
- Exact mode, APPROX_LSB=2, n=16'd200, d=8'd7, approx_en=0:
  - Required: q=28, r=4, ovf=0, div_zero=0.
  - out_valid rises exactly 9 cycles after the input handshake.
- Approx mode, n=16'd200, d=8'd7, approx_en=1:
  - Required: q and r match a bit-accurate reference model of the cell definitions.
  - Compare the exact result (q=28, r=4) against the model value; do not hard-code the approximate result.
- Divide by zero, n=16'h1234, d=0:
  - Required: q=8'hFF, r=8'h34, div_zero=1.
- Overflow, n=16'h0A00, d=8'h05:
  - Required: ovf=1; q and r match the truncated algorithm output from the model.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - Required: q, r and flags stay stable, in_ready=0, and a pulsed in_valid is ignored.
  - After out_ready=1, in_ready returns to 1 one cycle later.
- Assert rst at RUN step 3:
  - Required: out_valid=0, in_ready=1 and q=r=0 immediately (asynchronously).
  - The next operation completes correctly.
  - With SEQ_APPROX_DIVIDER_STATS_EN defined, err_cnt is also 0 immediately.

Source files
------------

// File: rtl/seq_approx_divider.sv
// Iterative restoring divider with an approximate low-order subtractor slice.
// Optional error statistics: define SEQ_APPROX_DIVIDER_STATS_EN.
module seq_approx_divider #(
    parameter int DW         = 8,
    parameter int QW         = 8,
    parameter int APPROX_LSB = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW+DW-1:0] n,
    input  logic [DW-1:0]    d,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    q,
    output logic [DW-1:0]    r,
    output logic             div_zero,
    output logic             ovf
`ifdef SEQ_APPROX_DIVIDER_STATS_EN
    ,
    output logic [15:0]      err_cnt
`endif
);

    localparam int NW = QW + DW;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [DW-1:0] rem;
    logic [DW-1:0] dreg;
    logic [QW-1:0] nlo;
    logic [QW-1:0] qreg;
    logic          ap;
    logic [CW-1:0] cnt;
    logic [DW:0]   tr;
    logic [DW:0]   sub;
    logic          qbit;
    logic          accept;

    // Ripple borrow subtractor; approximate cells drop their borrow-in.
    function automatic logic [DW:0] sub_step(
        input logic [DW-1:0] x,
        input logic [DW-1:0] y,
        input logic          apx
    );
        logic          b;
        logic [DW-1:0] df;
        b  = 1'b0;
        df = '0;
        for (int j = 0; j < DW; j++) begin
            if (apx && (j < APPROX_LSB)) begin
                df[j] = x[j];
                b     = ~x[j] & y[j];
            end else begin
                df[j] = x[j] ^ y[j] ^ b;
                b     = (~x[j] & y[j]) | (~(x[j] ^ y[j]) & b);
            end
        end
        return {b, df};
    endfunction

    assign tr     = {rem, nlo[QW-1]};
    assign sub    = sub_step(tr[DW-1:0], dreg, ap);
    assign qbit   = tr[DW] | ~sub[DW];
    assign accept = in_valid & in_ready;
    assign q      = qreg;
    assign r      = rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = RUN;
            end
            RUN: begin
                if (cnt == '0) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            dreg     <= '0;
            nlo      <= '0;
            qreg     <= '0;
            ap       <= 1'b0;
            cnt      <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            rem      <= n[NW-1:QW];
            nlo      <= n[QW-1:0];
            dreg     <= d;
            ap       <= approx_en;
            cnt      <= CW'(QW - 1);
            div_zero <= (d == '0);
            ovf      <= (n[NW-1:QW] >= d);
        end else if (state == RUN) begin
            rem  <= qbit ? sub[DW-1:0] : tr[DW-1:0];
            nlo  <= nlo << 1;
            qreg <= (qreg << 1) | QW'(qbit);
            if (cnt != '0) cnt <= cnt - CW'(1);
        end
    end

`ifdef SEQ_APPROX_DIVIDER_STATS_EN
    logic [DW-1:0] ex_rem;
    logic [QW-1:0] ex_q;
    logic [DW:0]   ex_t;
    logic [DW:0]   ex_sub;
    logic          ex_bit;

    // Shadow exact datapath shares the shifted dividend bits.
    assign ex_t   = {ex_rem, nlo[QW-1]};
    assign ex_sub = sub_step(ex_t[DW-1:0], dreg, 1'b0);
    assign ex_bit = ex_t[DW] | ~ex_sub[DW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rem  <= '0;
            ex_q    <= '0;
            err_cnt <= '0;
        end else begin
            if (accept) begin
                ex_rem <= n[NW-1:QW];
            end else if (state == RUN) begin
                ex_rem <= ex_bit ? ex_sub[DW-1:0] : ex_t[DW-1:0];
                ex_q   <= (ex_q << 1) | QW'(ex_bit);
            end
            if (out_valid && out_ready && ap &&
                (qreg != ex_q) && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
